picorv32_wb_bridge: RTL

Converts the PicoRV32 native memory interface (valid/ready, single outstanding access) into a Wishbone B3 classic single-cycle master port. It sits between the `picorv32_top` core and the tile's `wb_bus_b3` master input, upstream of the bus alongside the network-adapter master. It handles slave retry with bounded back-off and error termination, and records the address of the most recent failure.

---
 rtl/picorv32_wb_pkg.sv | 14 +
 rtl/wb_watchdog.sv | 34 +++
 rtl/picorv32_wb_bridge.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/picorv32_wb_pkg.sv
// Shared types and Wishbone constants for the PicoRV32-to-Wishbone bridge.
package picorv32_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BACKOFF,
        RESP
    } bridge_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_watchdog.sv
// Loadable down-counter; expire_o pulses on the last enabled cycle of the count.
module wb_watchdog #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/picorv32_wb_bridge.sv
// PicoRV32 native memory port to Wishbone B3 classic master with retry/error
// handling. Define PICORV32_WB_TIMEOUT_EN to build the REQ-state watchdog.
module picorv32_wb_bridge
    import picorv32_wb_pkg::*;
#(
    parameter int unsigned MAX_RETRY      = 4,
    parameter int unsigned RETRY_DELAY    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_sys_n,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    output logic        bus_err_o,
    output logic [31:0] err_adr_o,
    output logic        err_instr_o,
    output logic        timeout_o,
    input  logic        err_clr_i
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] MAX_RTY  = RW'(MAX_RETRY);
    localparam logic [7:0]    DLY_INIT = 8'(RETRY_DELAY - 1);

    bridge_state_t state_q, state_d;
    logic [31:0]   adr_q, adr_d, dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d, instr_q, instr_d, cyc_q, cyc_d;
    logic [RW-1:0] rty_cnt_q, rty_cnt_d;
    logic [7:0]    dly_q, dly_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d, err_adr_q, err_adr_d;
    logic          bus_err_q, bus_err_d, err_instr_q, err_instr_d;
    logic          timeout_q, timeout_d;
    logic          fail, fail_to, wd_expire;

`ifdef PICORV32_WB_TIMEOUT_EN
    // Reloaded whenever outside REQ, so every entry to REQ starts a fresh count.
    wb_watchdog #(.W(32)) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_sys_n),
        .load_i     (state_q != REQ),
        .load_val_i (32'(TIMEOUT_CYCLES)),
        .en_i       (state_q == REQ),
        .expire_o   (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        instr_d     = instr_q;
        cyc_d       = cyc_q;
        rty_cnt_d   = rty_cnt_q;
        dly_d       = dly_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;
        err_adr_d   = err_adr_q;
        err_instr_d = err_instr_q;
        timeout_d   = timeout_q;
        fail        = 1'b0;
        fail_to     = 1'b0;
        if (err_clr_i) begin
            bus_err_d = 1'b0;
            timeout_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                rty_cnt_d = '0;
                if (mem_valid) begin
                    adr_d   = mem_addr & ~32'h3;
                    we_d    = |mem_wstrb;
                    sel_d   = (|mem_wstrb) ? mem_wstrb : 4'hF;
                    dat_d   = mem_wdata;
                    instr_d = mem_instr;
                    cyc_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (wbm_err_i) begin
                    fail = 1'b1;
                end else if (wbm_ack_i) begin
                    rdata_d = wbm_dat_i;
                    ready_d = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = RESP;
                end else if (wbm_rty_i) begin
                    if (rty_cnt_q < MAX_RTY) begin
                        rty_cnt_d = rty_cnt_q + 1'b1;
                        dly_d     = DLY_INIT;
                        cyc_d     = 1'b0;
                        state_d   = BACKOFF;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (wd_expire) begin
                    fail    = 1'b1;
                    fail_to = 1'b1;
                end
            end
            BACKOFF: begin
                if (dly_q == '0) begin
                    cyc_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A failure in the same cycle as err_clr_i leaves the flags set.
        if (fail) begin
            rdata_d     = ERR_RDATA;
            bus_err_d   = 1'b1;
            timeout_d   = fail_to;
            err_adr_d   = adr_q;
            err_instr_d = instr_q;
            ready_d     = 1'b1;
            cyc_d       = 1'b0;
            state_d     = RESP;
        end
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            instr_q     <= 1'b0;
            cyc_q       <= 1'b0;
            rty_cnt_q   <= '0;
            dly_q       <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            err_adr_q   <= '0;
            err_instr_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            instr_q     <= instr_d;
            cyc_q       <= cyc_d;
            rty_cnt_q   <= rty_cnt_d;
            dly_q       <= dly_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            err_adr_q   <= err_adr_d;
            err_instr_q <= err_instr_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mem_ready   = ready_q;
    assign mem_rdata   = rdata_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_we_o    = we_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_cti_o   = WB_CTI_CLASSIC;
    assign wbm_bte_o   = WB_BTE_LINEAR;
    assign bus_err_o   = bus_err_q;
    assign err_adr_o   = err_adr_q;
    assign err_instr_o = err_instr_q;
    assign timeout_o   = timeout_q;

endmodule
